// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky hit bitmap, reports each newly covered point's global index once.
// Optional hit_events statistics counter enabled by defining COVER_TOGGLE_STATS_EN.
module cover_toggle_collector #(
  parameter int WIDTH       = 8,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] covered_count,
  output logic                       all_covered,
  output logic [31:0]                hit_events
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic int lowest_set(input logic [WIDTH-1:0] v);
    int idx;
    idx = 0;
    for (int i = WIDTH-1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      hit_map;
  logic [WIDTH-1:0]      newly_p0;
  logic [WIDTH-1:0]      pend_p1;
  logic [WIDTH-1:0]      pop_mask;
  logic                  pop;
  int                    pop_idx;
  logic [IDX_W-1:0]      idx_p2;
  logic [CW-1:0]         cnt_p1;

  // Stage 0: strobes against the sticky bitmap
  assign newly_p0 = valid & ~hit_map;

  // Stage 1 -> 2: pick lowest pending point when the output slot is free or being drained
  assign pop      = (|pend_p1) && ((state_q == EMPTY) || out_ready);
  assign pop_idx  = lowest_set(pend_p1);
  assign pop_mask = pop ? (WIDTH'(1) << pop_idx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (|pend_p1) state_d = HOLD;
        HOLD:    if (out_ready && !(|pend_p1)) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_map <= '0;
      pend_p1 <= '0;
      cnt_p1  <= '0;
      idx_p2  <= '0;
    end else if (clear) begin
      hit_map <= '0;
      pend_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      hit_map <= hit_map | valid;
      pend_p1 <= (pend_p1 & ~pop_mask) | newly_p0;
      cnt_p1  <= cnt_p1 + popcount(newly_p0);
      if (pop) idx_p2 <= IDX_W'(COVER_INDEX) + IDX_W'(pop_idx);
    end
  end

  assign out_index     = idx_p2;
  assign covered_count = cnt_p1;
  assign all_covered   = (cnt_p1 == CW'(WIDTH));

`ifdef COVER_TOGGLE_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] events_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      events_q <= '0;
    end else if (clear) begin
      events_q <= '0;
    end else begin
      events_q <= sat_add32(events_q, 32'(popcount(valid)));
    end
  end

  assign hit_events = events_q;
`else
  assign hit_events = '0;
`endif

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector: vector table plus hand-written corner sequences,
// with a queue scoreboard of expected out_index values.
module tb_cover_toggle_collector;
  localparam int WIDTH = 8;
  localparam int CIDX  = 100;
  localparam int IDX_W = 32;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] valid;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [3:0]       covered_count;
  logic             all_covered;
  logic [31:0]      hit_events;

  cover_toggle_collector #(
    .WIDTH(WIDTH), .COVER_INDEX(CIDX), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_count(covered_count), .all_covered(all_covered), .hit_events(hit_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] sbq[$];
  logic [31:0] mon_exp;
  logic [7:0]  m_hit;
  int unsigned m_events;

  typedef struct {
    logic [7:0] vec;
    logic [3:0] cnt;
    logic       all;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_events();
`ifdef COVER_TOGGLE_STATS_EN
    return m_events;
`else
    return 32'd0;
`endif
  endfunction

  // One driven cycle; bench model records which points become newly covered.
  task automatic cycle(input logic [7:0] v, input logic clr);
    valid = v;
    clear = clr;
    if (clr) begin
      m_hit = '0;
      m_events = 0;
      sbq.delete();
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          m_events++;
          if (!m_hit[i]) sbq.push_back(32'(CIDX + i));
        end
      end
      m_hit = m_hit | v;
    end
    @(posedge clock);
    #1;
    valid = '0;
    clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    @(posedge clock);
    #1;
    chk("drain_left", sbq.size(), 0);
    sbq.delete();
  endtask

  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL emit_unexpected got %0d expected none", out_index);
      end else begin
        mon_exp = sbq.pop_front();
        if (out_index !== mon_exp) begin
          errors++;
          $display("FAIL emit_index got %0d expected %0d", out_index, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{vec: 8'h05, cnt: 4'd2, all: 1'b0};
    tbl[1] = '{vec: 8'h05, cnt: 4'd2, all: 1'b0};
    tbl[2] = '{vec: 8'h0C, cnt: 4'd3, all: 1'b0};
    tbl[3] = '{vec: 8'h30, cnt: 4'd5, all: 1'b0};
    tbl[4] = '{vec: 8'h00, cnt: 4'd5, all: 1'b0};
    tbl[5] = '{vec: 8'hC2, cnt: 4'd8, all: 1'b1};

    m_hit = '0;
    m_events = 0;
    reset = 1'b0;
    valid = '0;
    clear = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_count", covered_count, 0);
    chk("rst_all", all_covered, 0);
    chk("rst_events", hit_events, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Table: cumulative coverage, drained between rows
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].vec, 1'b0);
      chk($sformatf("tbl%0d_count", i), covered_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_all", i), all_covered, tbl[i].all);
      drain();
    end
    chk("tbl_events", hit_events, exp_events());

    // Repeated strobe on one point reports once
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) cycle(8'h01, 1'b0);
    drain();
    chk("rep_count", covered_count, 1);
    chk("rep_events", hit_events, exp_events());

    // Back-pressure: held index stays stable while a lower point arrives
    cycle(8'h00, 1'b1);
    out_ready = 1'b0;
    cycle(8'h08, 1'b0);
    cycle(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_index", out_index, CIDX + 3);
    end
    out_ready = 1'b1;
    drain();
    chk("hold_count", covered_count, 2);

    // All points in one cycle
    cycle(8'h00, 1'b1);
    cycle(8'hFF, 1'b0);
    chk("full_all", all_covered, 1);
    chk("full_count", covered_count, 8);
    drain();

    // Clear beats a same-cycle strobe
    cycle(8'h00, 1'b1);
    cycle(8'h10, 1'b1);
    chk("clr_count", covered_count, 0);
    chk("clr_valid", out_valid, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("clr_valid_later", out_valid, 0);
    cycle(8'h10, 1'b0);
    drain();
    chk("clr_rehit_count", covered_count, 1);

    // Asynchronous reset mid-handshake
    cycle(8'h00, 1'b1);
    out_ready = 1'b0;
    cycle(8'h04, 1'b0);
    @(posedge clock);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    m_hit = '0;
    m_events = 0;
    sbq.delete();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_index", out_index, 0);
    chk("arst_count", covered_count, 0);
    chk("arst_all", all_covered, 0);
    chk("arst_events", hit_events, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_count", covered_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 Parameter WIDTH, default 8: number of toggle cover points collected.
REQ-002 Parameter COVER_INDEX, default 0: global index of cover point 0.
REQ-003 Parameter IDX_W, default 32: width of the reported index.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 valid  input  WIDTH  per-point hit strobe, one bit per cover point, sampled every cycle.
REQ-007 clear  input  1  synchronous clear of all collected coverage.
REQ-008 out_valid  output  1  a newly covered index is presented.
REQ-009 out_ready  input  1  consumer accepts out_index.
REQ-010 out_index  output  IDX_W  global index (COVER_INDEX + i) of a newly covered point.
REQ-011 covered_count  output  $clog2(WIDTH+1)  number of distinct points hit since reset or clear.
REQ-012 all_covered  output  1  high when covered_count == WIDTH.
REQ-013 hit_events  output  32  total hit strobes seen (see Configuration).

Function
REQ-014 The block SHALL keep a sticky hit bitmap; bit i sets on the first cycle valid[i]=1 and stays set until reset or clear.
REQ-015 A point is newly covered when valid[i]=1 and hit[i]=0; only newly covered points are reported, each exactly once per reset/clear epoch.
REQ-016 Newly covered bits SHALL be OR-ed into a pending vector on the next edge (cycle t strobe -> pending at t+1).
REQ-017 Output FSM states: EMPTY (out_valid=0), HOLD (out_valid=1).
REQ-018 EMPTY -> HOLD when pending != 0: load out_index with COVER_INDEX + lowest set pending index and clear that pending bit on the same edge (earliest out_valid at t+2).
REQ-019 HOLD with out_valid & out_ready: if pending != 0, reload the next lowest index in the same edge (stay HOLD, back-to-back throughput of 1/cycle); otherwise go to EMPTY.
REQ-020 HOLD with out_ready=0: out_valid and out_index SHALL remain stable regardless of new pending bits.
REQ-021 covered_count SHALL increase on the edge after a strobe by popcount(newly covered bits); multiple points in one cycle are all counted and all queued.
REQ-022 A repeated strobe on an already-hit point SHALL neither queue nor count.
REQ-023 clear=1 SHALL zero bitmap, pending, covered_count and go to EMPTY on the next edge; clear takes priority over valid in the same cycle (that cycle's strobes are dropped) and over an out handshake.
REQ-024 all_covered is combinational from covered_count; out_index arithmetic is modulo 2^IDX_W.

Reset
REQ-025 On reset low, asynchronously: bitmap=0, pending=0, FSM=EMPTY, out_valid=0, out_index=0, covered_count=0, all_covered=0, hit_events=0.
REQ-026 Reset asserted mid-handshake discards the held index; no index is re-emitted after release unless its point is hit again.

Configuration
REQ-027 Macro COVER_TOGGLE_STATS_EN defined: hit_events SHALL add popcount(valid) every non-clear cycle, saturating at 32'hFFFF_FFFF, zeroed by clear.
REQ-028 Macro undefined: hit_events SHALL be tied to 0 and no counter logic is instantiated; all other behaviour is unchanged.

Verification
REQ-029 COVER_INDEX=100, valid=8'h05 one cycle, out_ready=1 -> out_index 100 then 102 on consecutive cycles, covered_count=2.
REQ-030 valid=8'h01 repeated 10 cycles -> exactly one out_index=COVER_INDEX report, covered_count=1; with STATS_EN hit_events=10.
REQ-031 out_ready=0, hit point 3 then point 0 -> out_index stays COVER_INDEX+3 until accepted, then COVER_INDEX+0.
REQ-032 valid=8'hFF one cycle -> all_covered=1 after one edge; 8 indices emitted in ascending order with out_ready=1.
REQ-033 clear=1 with valid=8'h10 same cycle -> covered_count=0, out_valid=0, point 4 not reported; next valid=8'h10 reports it.
REQ-034 reset low while out_valid=1 -> out_valid=0 immediately, all counters 0 after release.
